// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage. Keeps the PC, issues one memory request
//            at a time and buffers returned words in a small FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000,
    parameter int          DEPTH    = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        Request_Alt_PC,
    input  logic [31:0] Alt_PC,
    output logic [31:0] Instr_address_2IM,
    output logic        Instr_req_2IM,
    input  logic        Instr_ack_fIM,
    input  logic [31:0] Instr1_fIM,
    output logic [31:0] Instr1_OUT,
    output logic [31:0] Instr_PC_OUT,
    output logic [31:0] Instr_PC_Plus4,
    output logic        Instr_Valid_OUT
);

    localparam int           AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]  DEPTH_W = DEPTH[AW:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t        state;
    logic [31:0]   pc;
    logic [31:0]   fifo_instr [DEPTH];
    logic [31:0]   fifo_pc    [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          in_flight;
    logic          push;
    logic          pop;
    logic          room;
    logic          may_issue;

    assign in_flight  = (state == WAIT) || (state == DROP);
    assign push       = (state == WAIT) && Instr_ack_fIM;
    assign pop        = Instr_Valid_OUT && !STALL;
    assign count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    assign room       = count_next < DEPTH_W;
    assign may_issue  = (state == IDLE) || (in_flight && Instr_ack_fIM);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state             <= IDLE;
            pc                <= RESET_PC;
            Instr_address_2IM <= '0;
            rd_ptr            <= '0;
            wr_ptr            <= '0;
            count             <= '0;
        end else if (Request_Alt_PC) begin
            // Redirect flushes everything; an in-flight request is left to
            // complete in DROP so its late response cannot be mistaken.
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            pc     <= {Alt_PC[31:2], 2'b00};
            state  <= (in_flight && !Instr_ack_fIM) ? DROP : IDLE;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            if (may_issue) begin
                if (room) begin
                    state             <= WAIT;
                    Instr_address_2IM <= pc;
                    pc                <= pc + 32'd4;
                end else begin
                    state <= IDLE;
                end
            end
        end
    end

    // Storage needs no reset: entries are only visible while counted valid.
    always_ff @(posedge CLK) begin
        if (push && !Request_Alt_PC) begin
            fifo_instr[wr_ptr] <= Instr1_fIM;
            fifo_pc[wr_ptr]    <= Instr_address_2IM;
        end
    end

    assign Instr_req_2IM   = in_flight;
    assign Instr_Valid_OUT = (count != '0);
    assign Instr1_OUT      = Instr_Valid_OUT ? fifo_instr[rd_ptr] : '0;
    assign Instr_PC_OUT    = Instr_Valid_OUT ? fifo_pc[rd_ptr] : '0;
    assign Instr_PC_Plus4  = Instr_Valid_OUT ? (fifo_pc[rd_ptr] + 32'd4) : '0;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed bench for fetch_unit with a responding memory model and
//            request/output scoreboards.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        CLK            = 1'b0;
    logic        RESET          = 1'b0;
    logic        STALL          = 1'b0;
    logic        Request_Alt_PC = 1'b0;
    logic [31:0] Alt_PC         = '0;
    logic        Instr_ack_fIM  = 1'b0;
    logic [31:0] Instr1_fIM     = '0;
    logic [31:0] Instr_address_2IM;
    logic        Instr_req_2IM;
    logic [31:0] Instr1_OUT;
    logic [31:0] Instr_PC_OUT;
    logic [31:0] Instr_PC_Plus4;
    logic        Instr_Valid_OUT;

    fetch_unit #(
        .RESET_PC (32'hBFC00000),
        .DEPTH    (2)
    ) dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .STALL             (STALL),
        .Request_Alt_PC    (Request_Alt_PC),
        .Alt_PC            (Alt_PC),
        .Instr_address_2IM (Instr_address_2IM),
        .Instr_req_2IM     (Instr_req_2IM),
        .Instr_ack_fIM     (Instr_ack_fIM),
        .Instr1_fIM        (Instr1_fIM),
        .Instr1_OUT        (Instr1_OUT),
        .Instr_PC_OUT      (Instr_PC_OUT),
        .Instr_PC_Plus4    (Instr_PC_Plus4),
        .Instr_Valid_OUT   (Instr_Valid_OUT)
    );

    always #5 CLK = ~CLK;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_req [$];
    logic [63:0] exp_out [$];
    logic        mem_on    = 1'b0;
    logic        dropped   = 1'b0;
    logic        prev_req  = 1'b0;
    logic        prev_ack  = 1'b0;
    logic [31:0] prev_addr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One cycle: observe at the falling edge, then drive inputs for the next rising edge.
    task automatic tick(input logic stall, input logic redir, input logic [31:0] alt);
        logic [31:0] e;
        logic [63:0] eo;
        @(negedge CLK);
        if (Instr_req_2IM && (!prev_req || prev_ack)) begin
            if (exp_req.size() > 0) begin
                e = exp_req.pop_front();
                chk("req_addr", Instr_address_2IM, e);
            end
        end else if (Instr_req_2IM && prev_req) begin
            chk("req_hold", Instr_address_2IM, prev_addr);
        end
        if (Instr_Valid_OUT) begin
            if (exp_out.size() == 0) begin
                chk("spurious_valid", {31'b0, Instr_Valid_OUT}, 32'd0);
            end else begin
                eo = exp_out[0];
                chk("head_pc", Instr_PC_OUT, eo[63:32]);
                chk("head_instr", Instr1_OUT, eo[31:0]);
                chk("head_plus4", Instr_PC_Plus4, eo[63:32] + 32'd4);
                if (!stall && !redir) exp_out.delete(0);
            end
        end else begin
            chk("zero_when_empty", Instr1_OUT | Instr_PC_OUT | Instr_PC_Plus4, 32'd0);
        end
        STALL          = stall;
        Request_Alt_PC = redir;
        Alt_PC         = alt;
        if (Instr_req_2IM && mem_on) begin
            Instr_ack_fIM = 1'b1;
            Instr1_fIM    = mem_word(Instr_address_2IM);
            if (!dropped && !redir) exp_out.push_back({Instr_address_2IM, Instr1_fIM});
            dropped = 1'b0;
        end else begin
            Instr_ack_fIM = 1'b0;
            Instr1_fIM    = 32'hDEAD_BEEF;
        end
        if (redir) begin
            exp_out.delete();
            if (Instr_req_2IM && !Instr_ack_fIM) dropped = 1'b1;
        end
        prev_req  = Instr_req_2IM;
        prev_ack  = Instr_ack_fIM;
        prev_addr = Instr_address_2IM;
    endtask

    task automatic do_reset(input logic stale_ack);
        @(negedge CLK);
        RESET          = 1'b0;
        STALL          = 1'b0;
        Request_Alt_PC = 1'b0;
        Instr_ack_fIM  = stale_ack;
        Instr1_fIM     = 32'h1234_5678;
        #1;
        chk("rst_async_valid", {31'b0, Instr_Valid_OUT}, 32'd0);
        chk("rst_async_req", {31'b0, Instr_req_2IM}, 32'd0);
        repeat (2) begin
            @(negedge CLK);
            chk("rst_valid", {31'b0, Instr_Valid_OUT}, 32'd0);
            chk("rst_req", {31'b0, Instr_req_2IM}, 32'd0);
            chk("rst_addr", Instr_address_2IM, 32'd0);
            chk("rst_data", Instr1_OUT | Instr_PC_OUT | Instr_PC_Plus4, 32'd0);
        end
        @(negedge CLK);
        RESET         = 1'b1;
        Instr_ack_fIM = 1'b0;
        exp_req.delete();
        exp_out.delete();
        mem_on   = 1'b0;
        dropped  = 1'b0;
        prev_req = 1'b0;
        prev_ack = 1'b0;
    endtask

    task automatic drain(input int n);
        mem_on = 1'b0;
        repeat (n) tick(1'b0, 1'b0, 32'd0);
        chk("out_drained", 32'(exp_out.size()), 32'd0);
        chk("req_all_seen", 32'(exp_req.size()), 32'd0);
    endtask

    initial begin
        // Sequential fetch, no stall
        do_reset(1'b0);
        exp_req = '{32'hBFC00000, 32'hBFC00004, 32'hBFC00008};
        mem_on  = 1'b1;
        tick(1'b0, 1'b0, 32'd0);
        chk("valid_not_early", {31'b0, Instr_Valid_OUT}, 32'd0);
        repeat (3) tick(1'b0, 1'b0, 32'd0);
        drain(4);

        // Stall fills the FIFO and stops requests
        do_reset(1'b0);
        exp_req = '{32'hBFC00000, 32'hBFC00004, 32'hBFC00008};
        mem_on  = 1'b1;
        repeat (6) tick(1'b1, 1'b0, 32'd0);
        chk("full_req_low", {31'b0, Instr_req_2IM}, 32'd0);
        chk("full_valid", {31'b0, Instr_Valid_OUT}, 32'd1);
        chk("full_head_pc", Instr_PC_OUT, 32'hBFC00000);
        repeat (3) tick(1'b0, 1'b0, 32'd0);
        drain(4);

        // Redirect while waiting; late response is dropped
        do_reset(1'b0);
        exp_req = '{32'hBFC00000, 32'h00400020, 32'h00400024};
        tick(1'b0, 1'b0, 32'd0);
        tick(1'b0, 1'b1, 32'h00400020);
        repeat (2) tick(1'b0, 1'b0, 32'd0);
        chk("drop_req_held", {31'b0, Instr_req_2IM}, 32'd1);
        mem_on = 1'b1;
        repeat (2) tick(1'b0, 1'b0, 32'd0);
        chk("drop_not_pushed", {31'b0, Instr_Valid_OUT}, 32'd0);
        tick(1'b0, 1'b0, 32'd0);
        chk("first_after_redirect", Instr_PC_OUT, 32'h00400020);
        tick(1'b0, 1'b0, 32'd0);
        drain(4);

        // Redirect coincident with ack, misaligned target
        do_reset(1'b0);
        exp_req = '{32'hBFC00000, 32'h00400020};
        tick(1'b0, 1'b0, 32'd0);
        mem_on = 1'b1;
        tick(1'b0, 1'b1, 32'h00400023);
        tick(1'b0, 1'b0, 32'd0);
        chk("coinc_empty", {31'b0, Instr_Valid_OUT}, 32'd0);
        chk("coinc_no_issue", {31'b0, Instr_req_2IM}, 32'd0);
        repeat (3) tick(1'b0, 1'b0, 32'd0);
        drain(4);

        // Reset mid-request with stale ack
        do_reset(1'b0);
        exp_req = '{32'hBFC00000};
        repeat (2) tick(1'b0, 1'b0, 32'd0);
        do_reset(1'b1);
        exp_req = '{32'hBFC00000};
        mem_on  = 1'b1;
        repeat (2) tick(1'b0, 1'b0, 32'd0);
        drain(3);

        // PC wrap at the top of the address space
        do_reset(1'b0);
        exp_req = '{32'hBFC00000, 32'hFFFFFFFC, 32'h00000000};
        tick(1'b0, 1'b0, 32'd0);
        tick(1'b0, 1'b1, 32'hFFFFFFFC);
        mem_on = 1'b1;
        repeat (3) tick(1'b0, 1'b0, 32'd0);
        chk("wrap_pc", Instr_PC_OUT, 32'hFFFFFFFC);
        chk("wrap_plus4", Instr_PC_Plus4, 32'd0);
        drain(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that produces the instruction stream consumed by the IF/ID pipeline latch. It keeps the PC and issues single-outstanding requests to instruction memory. Returned words are buffered in a small FIFO. The FIFO head is presented as instruction, PC and PC+4, honouring downstream STALL and branch/jump redirects.

Parameters:
RESET_PC, 32'hBFC00000, first fetch address after reset
DEPTH, 2, FIFO entries (power of 2, >=2)

Ports:
CLK  input  1  clock, all state on rising edge
RESET  input  1  reset, asynchronous, active-low
STALL  input  1  downstream latch frozen; do not pop FIFO head
Request_Alt_PC  input  1  redirect request (taken branch/jump/exception)
Alt_PC  input  32  redirect target
Instr_address_2IM  output  32  memory request address
Instr_req_2IM  output  1  request valid; held with address until ack
Instr_ack_fIM  input  1  one-cycle pulse, data valid for the outstanding request
Instr1_fIM  input  32  returned instruction word
Instr1_OUT  output  32  instruction at FIFO head, 0 when invalid
Instr_PC_OUT  output  32  address of Instr1_OUT, 0 when invalid
Instr_PC_Plus4  output  32  Instr_PC_OUT+4, 0 when invalid
Instr_Valid_OUT  output  1  FIFO non-empty

Behaviour:
- Reset (async, RESET=0): PC=RESET_PC, FIFO empty, state IDLE, Instr_req_2IM=0, Instr_address_2IM=0, all data outputs 0, Instr_Valid_OUT=0.
- Reset mid-request drops the outstanding request. Acks arriving in reset are ignored.
- State machine, one outstanding request max:
  - IDLE: no request outstanding.
  - WAIT: request outstanding; response is kept.
  - DROP: request outstanding; response is discarded.
  - Instr_req_2IM=1 iff state is WAIT or DROP.
- Room condition at each edge: count_next + 0 < DEPTH. count_next is the FIFO count after this cycle's push (ack in WAIT) and pop (Instr_Valid_OUT && !STALL).
- Normal edge, no redirect:
  - WAIT with ack: push {Instr1_fIM, Instr_address_2IM}.
  - IDLE or (WAIT/DROP with ack), with room: issue. State->WAIT, Instr_address_2IM<=PC, PC<=PC+4.
  - IDLE or (WAIT/DROP with ack), without room: state->IDLE.
  - WAIT/DROP without ack: hold state, hold address.
- Redirect edge (Request_Alt_PC=1), overrides everything above:
  - FIFO cleared; the pop is ignored.
  - PC<=Alt_PC with bits[1:0] forced to 0.
  - No new request is issued this edge.
  - State->DROP if a request is outstanding and no ack this cycle; else ->IDLE. An ack this cycle is discarded.
  - First fetch from Alt_PC issues on the next eligible edge.
- DROP with ack: the word is never pushed.
- Request_Alt_PC during DROP: updates PC; stays DROP.
- Outputs are combinational from registered FIFO head:
  - Instr_PC_Plus4 = head PC + 4, 32-bit wrap (32'hFFFFFFFC -> 0).
  - Zeroed when empty, so downstream sees a NOP bubble.
- Latency: ack at edge t makes the word visible at Instr_Valid_OUT in cycle t+1 (FIFO was empty, no redirect).
- Full FIFO with STALL=1: no issue; request stream stops. Resumes the edge after STALL drops (pop frees an entry).
- PC increments wrap modulo 2^32.

Test Plan:
- Reset, ack latency 1, STALL=0 -> addresses BFC00000, BFC00004, BFC00008 in successive requests. Outputs show PC BFC00000 / PC+4 BFC00004 with the returned words, one per ack.
- STALL=1 for 6 cycles with ack every cycle -> FIFO fills to 2, Instr_req_2IM drops. Head stays BFC00000 throughout. Release -> in-order BFC00000, 04, 08 with no loss or duplicate.
- Redirect to 0x00400020 while in WAIT, ack 3 cycles later -> that word is dropped (state DROP). Next request address is 00400020 and the first valid output PC is 00400020.
- Redirect coincident with ack -> word not pushed, FIFO empty next cycle, next request 00400020. Alt_PC=00400023 yields 00400020.
- RESET pulsed low mid-WAIT, stale ack during reset -> all outputs 0. First request after release is at RESET_PC.
- PC=FFFFFFFC fetched -> Instr_PC_Plus4=0 and next request address=0.
